// File: rtl/a2d_resp.sv
// SPI responder emulating an ADC128S-style A2D converter. The channel commanded in one frame
// is returned as a 12-bit result in the next; SPI pins are oversampled on clk.
module a2d_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] batt,
  input  logic [11:0] brake,
  input  logic [11:0] torque,
  output logic [2:0]  chnnl,
  output logic        done,
  output logic        err,
  output logic [7:0]  nfrm
);

  localparam logic [2:0] CH_BATT   = 3'd0;
  localparam logic [2:0] CH_BRAKE  = 3'd1;
  localparam logic [2:0] CH_TORQUE = 3'd4;

  typedef enum logic [1:0] {StWaitHi, StIdle, StShift} state_e;

  // [0],[1] synchronize; [2] holds the previous synchronized value for edge detection
  logic [2:0] ss_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  // Set once the synchronizers hold real pin values rather than their reset values
  logic [1:0] warm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b111;
      mosi_q <= 2'b00;
      warm_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], SS_n};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
      warm_q <= {warm_q[0], 1'b1};
    end
  end

  logic ss_sync, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_sync;

  assign ss_sync   = ss_q[1];
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign mosi_sync = mosi_q[1];

  logic [11:0] sel;

  always_comb begin
    sel = 12'h000;
    case (chnnl)
      CH_BATT:   sel = batt;
      CH_BRAKE:  sel = brake;
      CH_TORQUE: sel = torque;
      default:   sel = 12'h000;
    endcase
  end

  state_e      state_q;
  logic [15:0] tx_q;
  // Only the low 14 bits of the received word matter; the channel lands in [13:11]
  logic [13:0] rx_q;
  logic [4:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWaitHi;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      chnnl   <= CH_BATT;
      done    <= 1'b0;
      err     <= 1'b0;
      nfrm    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StWaitHi: begin
          if (warm_q[1] && ss_sync) state_q <= StIdle;
        end
        StIdle: begin
          if (ss_fall) begin
            tx_q    <= {4'b0000, sel};
            rx_q    <= '0;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          // SS_n rise takes priority over any coincident SCLK edge
          if (ss_rise) begin
            if (cnt_q == 5'd16) begin
              chnnl <= rx_q[13:11];
              done  <= 1'b1;
              nfrm  <= nfrm + 8'd1;
            end else begin
              err <= 1'b1;
            end
            state_q <= StIdle;
          end else if (sclk_rise) begin
            rx_q <= {rx_q[12:0], mosi_sync};
            if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
          end else if (sclk_fall && cnt_q != 5'd0) begin
            // The first fall precedes any rise and only opens bit 15's window
            tx_q <= {tx_q[14:0], 1'b0};
          end
        end
        default: state_q <= StWaitHi;
      endcase
    end
  end

  assign MISO = tx_q[15];

endmodule
